star_mapper: RTL
================

Name: star_mapper

Overview:
Controller that sequences the pixel RAM port after the raster scanner finds a bright seed pixel.
- Scans a clamped column window row by row from the seed and measures the star's bounding box.
- Blots each bright pixel to colour 0 so the scanner never finds the star again.
- Sits between the findWhite scanner (go/done handshake) and the 36x3 pixel RAM. It owns the RAM port while busy.

Parameters:
XSZ, 3, x coordinate width
YSZ, 3, y coordinate width
ADDRSZ, 6, RAM address width
COLSZ, 3, pixel colour width
MAX_X, 6, image width in pixels
MAX_Y, 6, image height in pixels
RADIUS, 2, columns scanned each side of seedX
THRESHOLD, 0, pixel is bright when value > THRESHOLD

Ports:
clk  in  1  single clock, rising edge
resetn  in  1  synchronous active-low reset
go  in  1  level request from scanner; held until done seen
seedX  in  XSZ  seed column, sampled when go accepted
seedY  in  YSZ  seed row, sampled when go accepted
memAddr  out  ADDRSZ  RAM address, = y*MAX_X + x
memRdData  in  COLSZ  RAM q, valid 1 cycle after address
memWrEn  out  1  RAM write enable
memWrData  out  COLSZ  write data, constant 0
busy  out  1  high in every state except IDLE and WAIT_LOW
done  out  1  1-cycle pulse, box outputs valid
boxX  out  XSZ  leftmost bright column
boxY  out  YSZ  topmost bright row
boxW  out  XSZ  box width; 0 if no bright pixel
boxH  out  YSZ  box height; 0 if no bright pixel

Behaviour:
- Reset (resetn=0 at clk edge), from any state including mid-scan:
  - state=IDLE.
  - memWrEn, done, busy = 0 from the next cycle.
  - memAddr=0; all box outputs = 0.
  - No partial result is reported.
- Window per row:
  - xLo = max(0, seedX-RADIUS); xHi = min(MAX_X-1, seedX+RADIUS).
  - Computed in XSZ+1 bits so there is no underflow or wrap.
- States:
  - IDLE: if go, latch seeds, y=seedY, minX=MAX_X-1, maxX=0, rowCnt=0 -> ROW_INIT.
  - ROW_INIT: x=xLo, rowHit=0 -> READ.
  - READ: drive memAddr(x,y) -> WAIT.
  - WAIT: hold address, RAM latency -> EVAL.
  - EVAL:
    - If memRdData > THRESHOLD: memWrEn=1 at the same address, rowHit=1, minX=min(minX,x), maxX=max(maxX,x).
    - Then -> READ with x+1 if x<xHi, else -> ROW_END.
  - ROW_END:
    - If rowHit: rowCnt+1.
    - If !rowHit or y==MAX_Y-1 -> DONE.
    - Else y+1 -> ROW_INIT.
  - DONE:
    - done=1 for one cycle; register the box outputs -> WAIT_LOW.
    - Box values: boxX=minX, boxY=seedY, boxW=maxX-minX+1, boxH=rowCnt.
    - If rowCnt==0: boxX=seedX, boxW=0, boxH=0.
  - WAIT_LOW: stay until go==0, then -> IDLE. This prevents a restart on a go that is still held.
- Timing:
  - 3 cycles per pixel (READ/WAIT/EVAL), 1 cycle per ROW_INIT, 1 per ROW_END.
  - Latency from go to done = 1 + rows*(2 + 3*windowWidth) + 1 cycles, where rows includes the final dark row if one is scanned.
- Box outputs hold from DONE until the next go is accepted in IDLE.
- A dark pixel is never written. memWrEn is only ever high in EVAL.
- A bright pixel in the first row below seedX outside the window is not visited. The mapper scans rows >= seedY only; the scanner guarantees the seed is the raster-first pixel.

Decomposition:
- Shared package star_pkg holds:
  - MAX_X, MAX_Y, XSZ, YSZ, ADDRSZ, COLSZ, THRESHOLD.
  - State encoding localparams for IDLE, ROW_INIT, READ, WAIT, EVAL, ROW_END, DONE, WAIT_LOW.
- Reuse the existing address_translator (y*4 + y*2 + x) as the one sub-module instantiated for memAddr.
- Window clamp and min/max logic stay inline.

Test Plan:
- Reset values: hold resetn=0 for 2 cycles -> busy=0, done=0, memWrEn=0, all box outputs = 0.
- Plus-shaped star:
  - Stimulus: pixels (2,1),(1,2),(2,2),(3,2),(2,3)=7, all other pixels 0; go with seed (2,1).
  - Box: done after 1+4*(2+15)+1=70 cycles with box (1,1,3,3).
  - Memory: exactly 5 writes, all 5 pixel addresses read back 0.
- Corner clamp, single pixel (0,5): seed (0,5) -> window x 0..2, terminates on y==5, box (0,5,1,1), done after 1+(2+9)+1=13 cycles.
- Dark seed: seed (3,0) with an all-zero image -> done after 1+(2+15)+1=19 cycles, box (3,0,0,0), no memWrEn pulse.
- Out-of-window pixel: pixels (2,0),(5,1),(2,1) bright; seed (2,0).
  - Box (2,0,1,2).
  - (5,1) is untouched and still reads 7.
- Handshake and reset:
  - go held high after done -> stays in WAIT_LOW with busy=0 and no second done; drop go then raise it -> new scan starts.
  - Assert resetn=0 10 cycles into a scan -> IDLE next cycle, memWrEn=0, no done.

Source files
------------

// File: rtl/star_pkg.sv
// Shared constants and state encoding for the star mapper.
// Image geometry, coordinate/colour widths, scan radius and brightness threshold.
package star_pkg;

    localparam int XSZ       = 3;
    localparam int YSZ       = 3;
    localparam int ADDRSZ    = 6;
    localparam int COLSZ     = 3;
    localparam int MAX_X     = 6;
    localparam int MAX_Y     = 6;
    localparam int RADIUS    = 2;
    localparam int THRESHOLD = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ROW_INIT = 3'd1,
        ST_READ     = 3'd2,
        ST_WAIT     = 3'd3,
        ST_EVAL     = 3'd4,
        ST_ROW_END  = 3'd5,
        ST_DONE     = 3'd6,
        ST_WAIT_LOW = 3'd7
    } state_e;

endpackage

// File: rtl/star_mapper_if.sv
// Bundle of the scanner handshake and pixel RAM port used by star_mapper.
//   go/seedX/seedY      : request from the findWhite scanner
//   busy/done/box*      : status and measured bounding box back to the scanner
//   memAddr/memRdData   : RAM read port (1-cycle read latency)
//   memWrEn/memWrData   : RAM write port (used to blot bright pixels)
// slave  = the mapper side, master = scanner/RAM side.
interface star_mapper_if;
    import star_pkg::*;

    logic              go;
    logic [XSZ-1:0]    seedX;
    logic [YSZ-1:0]    seedY;
    logic [ADDRSZ-1:0] memAddr;
    logic [COLSZ-1:0]  memRdData;
    logic              memWrEn;
    logic [COLSZ-1:0]  memWrData;
    logic              busy;
    logic              done;
    logic [XSZ-1:0]    boxX;
    logic [YSZ-1:0]    boxY;
    logic [XSZ-1:0]    boxW;
    logic [YSZ-1:0]    boxH;

    modport slave (
        input  go, seedX, seedY, memRdData,
        output memAddr, memWrEn, memWrData, busy, done, boxX, boxY, boxW, boxH
    );

    modport master (
        output go, seedX, seedY, memRdData,
        input  memAddr, memWrEn, memWrData, busy, done, boxX, boxY, boxW, boxH
    );

endinterface

// File: rtl/star_mapper_address_translator.sv
// Maps pixel coordinates to a linear RAM address: addr = y*6 + x,
// built from shifts (y*4 + y*2) so no multiplier is needed.
//   x_i    : column
//   y_i    : row
//   addr_o : RAM address
module address_translator
    import star_pkg::*;
(
    input  logic [XSZ-1:0]    x_i,
    input  logic [YSZ-1:0]    y_i,
    output logic [ADDRSZ-1:0] addr_o
);
    logic [ADDRSZ-1:0] x_w;
    logic [ADDRSZ-1:0] y_w;

    assign x_w    = ADDRSZ'(x_i);
    assign y_w    = ADDRSZ'(y_i);
    assign addr_o = (y_w << 2) + (y_w << 1) + x_w;

endmodule

// File: rtl/star_mapper.sv
// Star mapper: after the scanner reports a bright seed pixel, walks a clamped
// column window row by row from the seed, blots every bright pixel to 0 and
// reports the star's bounding box. Owns the RAM port while busy.
//   clk, resetn : clock and synchronous active-low reset
//   bus (slave) : scanner handshake, box results and RAM port
//
// state    | meaning
// IDLE     | waiting for go; latches seed on accept
// ROW_INIT | start a row at the left window edge
// READ     | present pixel address
// WAIT     | RAM latency; read data sampled here
// EVAL     | blot bright pixel, update extents, step column
// ROW_END  | count row, stop on dark row or last image row
// DONE     | done pulse, box outputs valid
// WAIT_LOW | wait for go to drop before accepting a new request
module star_mapper
    import star_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    star_mapper_if.slave bus
);
    localparam logic [XSZ:0]     RAD_W    = (XSZ+1)'(RADIUS);
    localparam logic [XSZ:0]     LAST_X_W = (XSZ+1)'(MAX_X - 1);
    localparam logic [XSZ-1:0]   LAST_X   = XSZ'(MAX_X - 1);
    localparam logic [YSZ-1:0]   LAST_Y   = YSZ'(MAX_Y - 1);
    localparam logic [COLSZ-1:0] THRESH   = COLSZ'(THRESHOLD);

    state_e            state_q;
    logic [XSZ-1:0]    seed_x_q, x_q, min_x_q, max_x_q, box_x_q, box_w_q;
    logic [YSZ-1:0]    seed_y_q, y_q, row_cnt_q, box_y_q, box_h_q;
    logic              row_hit_q, wr_en_q, busy_q, done_q;
    logic [XSZ:0]      seed_x_w, x_plus, x_lo, x_hi;
    logic [YSZ-1:0]    row_cnt_d;
    logic [ADDRSZ-1:0] mem_addr;

    // Window edges are formed one bit wider so seedX-RADIUS cannot wrap
    // and seedX+RADIUS cannot overflow before clamping.
    always_comb begin
        seed_x_w  = {1'b0, seed_x_q};
        x_plus    = seed_x_w + RAD_W;
        x_lo      = (seed_x_w >= RAD_W) ? (seed_x_w - RAD_W) : '0;
        x_hi      = (x_plus > LAST_X_W) ? LAST_X_W : x_plus;
        row_cnt_d = row_cnt_q + {{(YSZ-1){1'b0}}, row_hit_q};
    end

    address_translator u_addr (
        .x_i    (x_q),
        .y_i    (y_q),
        .addr_o (mem_addr)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            seed_x_q  <= '0;
            seed_y_q  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            min_x_q   <= '0;
            max_x_q   <= '0;
            row_cnt_q <= '0;
            row_hit_q <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            box_x_q   <= '0;
            box_y_q   <= '0;
            box_w_q   <= '0;
            box_h_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.go) begin
                        seed_x_q  <= bus.seedX;
                        seed_y_q  <= bus.seedY;
                        y_q       <= bus.seedY;
                        min_x_q   <= LAST_X;
                        max_x_q   <= '0;
                        row_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_ROW_INIT;
                    end
                end
                ST_ROW_INIT: begin
                    x_q       <= x_lo[XSZ-1:0];
                    row_hit_q <= 1'b0;
                    state_q   <= ST_READ;
                end
                ST_READ: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Read data is valid now; registering the decision here
                    // puts the blot write exactly in EVAL at the same address.
                    wr_en_q <= (bus.memRdData > THRESH);
                    state_q <= ST_EVAL;
                end
                ST_EVAL: begin
                    wr_en_q <= 1'b0;
                    if (wr_en_q) begin
                        row_hit_q <= 1'b1;
                        if (x_q < min_x_q) min_x_q <= x_q;
                        if (x_q > max_x_q) max_x_q <= x_q;
                    end
                    if ({1'b0, x_q} < x_hi) begin
                        x_q     <= x_q + XSZ'(1);
                        state_q <= ST_READ;
                    end else begin
                        state_q <= ST_ROW_END;
                    end
                end
                ST_ROW_END: begin
                    row_cnt_q <= row_cnt_d;
                    if (!row_hit_q || (y_q == LAST_Y)) begin
                        done_q  <= 1'b1;
                        box_y_q <= seed_y_q;
                        if (row_cnt_d == '0) begin
                            box_x_q <= seed_x_q;
                            box_w_q <= '0;
                            box_h_q <= '0;
                        end else begin
                            box_x_q <= min_x_q;
                            box_w_q <= max_x_q - min_x_q + XSZ'(1);
                            box_h_q <= row_cnt_d;
                        end
                        state_q <= ST_DONE;
                    end else begin
                        y_q     <= y_q + YSZ'(1);
                        state_q <= ST_ROW_INIT;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!bus.go) state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.memAddr   = mem_addr;
    assign bus.memWrEn   = wr_en_q;
    assign bus.memWrData = '0;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.boxX      = box_x_q;
    assign bus.boxY      = box_y_q;
    assign bus.boxW      = box_w_q;
    assign bus.boxH      = box_h_q;

endmodule
